conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_conv_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
//   Sequences one convolution window at a time for an external engine:
//   loads NTAP kernel weights, collects NTAP pixels, holds conv_start with
//   stable kernel/pixel buses until the engine reports conv_done (or a
//   timeout expires), inserts a one-cycle gap so the engine clears its
//   accumulator, then offers the captured result to a consumer.
//
//   Handshakes: a transfer on any valid/ready pair happens on the rising
//   edge where both valid and ready are high. Ready/valid outputs are
//   registered and depend only on the current state, never on the
//   partner's valid/ready in the same cycle.
//
// Ports
//   clk, reset            clock (rising edge), async active-low reset
//   k_valid/k_data/k_ready kernel weight stream (signed 9-bit)
//   k_clear               request kernel reload (FILL, no pixels taken yet)
//   px_valid/px_data/px_ready pixel stream (signed 9-bit)
//   conv_start            start/hold level to the engine (high in RUN only)
//   kernel_bus, x_bus     weight/pixel i at bits [9i+8:9i]
//   conv_done/conv_result engine result-valid pulse and signed result
//   out_valid/out_data/out_ready captured result to consumer
//   win_count             results delivered since reset (wraps)
//   err_tmo               sticky engine timeout flag
//   dbg_state             current FSM state encoding
// -----------------------------------------------------------------------------
module conv_sequencer #(
    parameter int NTAP = 21,
    parameter int TMO  = 255   // must fit the 8-bit cycle counter
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                k_valid,
    input  logic [8:0]          k_data,
    output logic                k_ready,
    input  logic                k_clear,
    input  logic                px_valid,
    input  logic [8:0]          px_data,
    output logic                px_ready,
    output logic                conv_start,
    output logic [9*NTAP-1:0]   kernel_bus,
    output logic [9*NTAP-1:0]   x_bus,
    input  logic                conv_done,
    input  logic [26:0]         conv_result,
    output logic                out_valid,
    output logic [26:0]         out_data,
    input  logic                out_ready,
    output logic [15:0]         win_count,
    output logic                err_tmo,
    output logic [2:0]          dbg_state
);

    localparam int              IDXW     = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAP - 1);
    localparam logic [7:0]      TMO_LIM  = 8'(TMO);

    typedef enum logic [2:0] {
        S_KLOAD = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   k_idx_q, p_idx_q;
    logic [7:0]        tmo_cnt_q;
    logic [9*NTAP-1:0] kernel_q, x_q;
    logic [26:0]       out_data_q;
    logic [15:0]       win_count_q;
    logic              err_tmo_q, have_res_q;
    logic              k_ready_q, px_ready_q, conv_start_q, out_valid_q;

    logic k_fire, px_fire, out_fire, fill_clear, tmo_hit;

    assign k_fire     = k_valid & k_ready_q;
    assign px_fire    = px_valid & px_ready_q;
    assign out_fire   = out_valid_q & out_ready;
    // Reload is only honoured before the first pixel of a window. If a pixel
    // is offered in that same cycle it completes its handshake but is
    // dropped, since the window restarts after the new kernel is loaded.
    assign fill_clear = (state_q == S_FILL) && k_clear && (p_idx_q == '0);
    // conv_done takes precedence over the timeout in the same cycle.
    assign tmo_hit    = (tmo_cnt_q == TMO_LIM) && !conv_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_KLOAD: if (k_fire && (k_idx_q == LAST_IDX)) state_d = S_FILL;
            S_FILL: begin
                if (fill_clear)                                state_d = S_KLOAD;
                else if (px_fire && (p_idx_q == LAST_IDX))     state_d = S_RUN;
            end
            S_RUN:   if (conv_done || tmo_hit) state_d = S_GAP;
            S_GAP:   state_d = have_res_q ? S_OUT : S_FILL;
            S_OUT:   if (out_fire) state_d = S_FILL;
            default: state_d = S_KLOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_KLOAD;
            k_idx_q      <= '0;
            p_idx_q      <= '0;
            tmo_cnt_q    <= '0;
            kernel_q     <= '0;
            x_q          <= '0;
            out_data_q   <= '0;
            win_count_q  <= '0;
            err_tmo_q    <= 1'b0;
            have_res_q   <= 1'b0;
            k_ready_q    <= 1'b0;
            px_ready_q   <= 1'b0;
            conv_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // Registered outputs follow the state being entered.
            k_ready_q    <= (state_d == S_KLOAD);
            px_ready_q   <= (state_d == S_FILL);
            conv_start_q <= (state_d == S_RUN);
            out_valid_q  <= (state_d == S_OUT);

            if ((state_q == S_KLOAD) && k_fire) begin
                kernel_q[9*int'(k_idx_q) +: 9] <= k_data;
                k_idx_q <= (k_idx_q == LAST_IDX) ? '0 : k_idx_q + 1'b1;
            end

            if ((state_q == S_FILL) && px_fire && !fill_clear) begin
                x_q[9*int'(p_idx_q) +: 9] <= px_data;
                p_idx_q <= (p_idx_q == LAST_IDX) ? '0 : p_idx_q + 1'b1;
            end

            // Counts RUN cycles; any other state holds it at zero so each
            // RUN entry starts from 0.
            tmo_cnt_q <= (state_q == S_RUN) ? tmo_cnt_q + 1'b1 : '0;

            if (state_q == S_RUN) begin
                if (conv_done) begin
                    out_data_q <= conv_result;
                    have_res_q <= 1'b1;
                end else if (tmo_hit) begin
                    err_tmo_q  <= 1'b1;
                    have_res_q <= 1'b0;
                end
            end

            if (out_fire) win_count_q <= win_count_q + 16'd1;
        end
    end

    assign k_ready    = k_ready_q;
    assign px_ready   = px_ready_q;
    assign conv_start = conv_start_q;
    assign kernel_bus = kernel_q;
    assign x_bus      = x_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign win_count  = win_count_q;
    assign err_tmo    = err_tmo_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_sequencer
//   Drives kernel/pixel streams, plays the convolution engine (computing its
//   result from the DUT's kernel_bus/x_bus), and checks results against a
//   dot-product reference model of the stimulus arrays. Directed vectors
//   come from a table; random windows, timeout, k_clear and reset sequences
//   follow.
// -----------------------------------------------------------------------------
module tb_conv_sequencer;

    localparam int NTAP = 21;
    localparam int TMO  = 255;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic                k_valid = 0, k_ready, k_clear = 0;
    logic [8:0]          k_data = '0;
    logic                px_valid = 0, px_ready;
    logic [8:0]          px_data = '0;
    logic                conv_start;
    logic [9*NTAP-1:0]   kernel_bus, x_bus;
    logic                conv_done = 0;
    logic [26:0]         conv_result = '0;
    logic                out_valid, out_ready = 0;
    logic [26:0]         out_data;
    logic [15:0]         win_count;
    logic                err_tmo;
    logic [2:0]          dbg_state;

    conv_sequencer #(.NTAP(NTAP), .TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready), .k_clear(k_clear),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .conv_start(conv_start), .kernel_bus(kernel_bus), .x_bus(x_bus),
        .conv_done(conv_done), .conv_result(conv_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .win_count(win_count), .err_tmo(err_tmo), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [26:0] exp_q[$];
    int          w_arr[NTAP];
    int          p_arr[NTAP];
    int          exp_wins = 0;
    logic        exp_err = 0;

    typedef struct {
        bit reload;
        int w_base;
        int w_step;
        int px;
        int delay;
        int hold;
        int exp_data;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain dot product of the stimulus.
    function automatic logic [26:0] model_dot();
        longint acc = 0;
        for (int i = 0; i < NTAP; i++) acc += longint'(w_arr[i]) * longint'(p_arr[i]);
        return acc[26:0];
    endfunction

    // Engine behaviour: multiply-accumulate over what the DUT presents.
    function automatic logic [26:0] bus_dot();
        logic signed [8:0] a, b;
        longint acc = 0;
        for (int i = 0; i < NTAP; i++) begin
            a = kernel_bus[9*i +: 9];
            b = x_bus[9*i +: 9];
            acc += longint'(a) * longint'(b);
        end
        return acc[26:0];
    endfunction

    function automatic bit kernel_matches();
        logic signed [8:0] s;
        for (int i = 0; i < NTAP; i++) begin
            s = kernel_bus[9*i +: 9];
            if (int'(s) != w_arr[i]) return 0;
        end
        return 1;
    endfunction

    function automatic bit x_matches();
        logic signed [8:0] s;
        for (int i = 0; i < NTAP; i++) begin
            s = x_bus[9*i +: 9];
            if (int'(s) != p_arr[i]) return 0;
        end
        return 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_kernel();
        int n;
        for (int i = 0; i < NTAP; i++) begin
            if ($urandom_range(3) == 0) begin k_valid = 0; tick(); end
            k_valid = 1;
            k_data  = w_arr[i][8:0];
            n = 0;
            while (!k_ready && n < 50) begin tick(); n++; end
            if (!k_ready) begin
                check("k_ready_wait", 0, 1);
                k_valid = 0;
                return;
            end
            tick();
        end
        k_valid = 0;
        check("kernel_bus", kernel_matches(), 1);
        check("kload_exit_k_ready", k_ready, 0);
        check("kload_exit_px_ready", px_ready, 1);
    endtask

    task automatic send_pixels(input int from, input int to, input bit spurious);
        int n;
        for (int i = from; i < to; i++) begin
            if ($urandom_range(3) == 0) begin px_valid = 0; tick(); end
            px_valid = 1;
            px_data  = p_arr[i][8:0];
            if (spurious) begin
                conv_done   = 1'($urandom_range(1));
                conv_result = 27'($urandom);
            end
            n = 0;
            while (!px_ready && n < 50) begin tick(); n++; end
            if (!px_ready) begin
                check("px_ready_wait", 0, 1);
                px_valid  = 0;
                conv_done = 0;
                return;
            end
            tick();
        end
        px_valid  = 0;
        conv_done = 0;
    endtask

    // Entered on the first RUN cycle; asserts conv_done in cycle 'delay'.
    task automatic run_engine(input int delay);
        logic [9*NTAP-1:0] kb, xb;
        bit ok;
        check("start_latency", conv_start, 1);
        check("x_bus", x_matches(), 1);
        kb = kernel_bus;
        xb = x_bus;
        ok = 1;
        for (int c = 1; c < delay; c++) begin
            tick();
            if (!conv_start || kernel_bus !== kb || x_bus !== xb || px_ready || out_valid) ok = 0;
        end
        check("run_hold", ok, 1);
        conv_result = bus_dot();
        conv_done   = 1;
        tick();
        conv_done   = 0;
        conv_result = 27'($urandom);
        check("gap_start_low", conv_start, 0);
        check("gap_no_valid", out_valid, 0);
        tick();
        check("out_latency", out_valid, 1);
    endtask

    task automatic drain_out(input int hold);
        logic [26:0] e;
        bit ok;
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("out_data", $signed(out_data), $signed(e));
        ok = 1;
        for (int h = 0; h < hold; h++) begin
            conv_done   = 1'($urandom_range(1));
            conv_result = 27'($urandom);
            tick();
            if (!out_valid || out_data !== e || px_ready || conv_start) ok = 0;
        end
        conv_done = 0;
        if (hold > 0) check("out_hold", ok, 1);
        out_ready = 1;
        tick();
        out_ready = 0;
        exp_wins++;
        check("win_count", win_count, exp_wins);
        check("out_drop", out_valid, 0);
        check("px_ready_after_out", px_ready, 1);
        check("err_tmo", err_tmo, exp_err);
    endtask

    task automatic do_window(input bit reload, input int delay, input int hold, input bit spurious);
        if (reload) begin
            if (!k_ready) begin
                k_clear = 1;
                tick();
                k_clear = 0;
                check("kclear_to_kload", k_ready, 1);
            end
            send_kernel();
        end
        exp_q.push_back(model_dot());
        send_pixels(0, NTAP, spurious);
        run_engine(delay);
        drain_out(hold);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        vecs[0] = '{1,    1, 1,    2, 20,  0,     462};
        vecs[1] = '{1,   -1, 0,  255,  5, 10,   -5355};
        vecs[2] = '{1,  -10, 1,    3,  1,  2,       0};
        vecs[3] = '{1,  255, 0, -256,  3,  1, -1370880};
        vecs[4] = '{0,  255, 0,    1,  2,  0,    5355};

        // Reset values
        tick(); tick();
        check("rst_k_ready", k_ready, 0);
        check("rst_px_ready", px_ready, 0);
        check("rst_conv_start", conv_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_win_count", win_count, 0);
        check("rst_err_tmo", err_tmo, 0);
        reset = 1;
        tick();
        check("k_ready_after_release", k_ready, 1);
        check("px_ready_in_kload", px_ready, 0);

        // Directed table
        foreach (vecs[v]) begin
            for (int i = 0; i < NTAP; i++) begin
                w_arr[i] = vecs[v].w_base + vecs[v].w_step * i;
                p_arr[i] = vecs[v].px;
            end
            check("table_model", $signed(model_dot()), vecs[v].exp_data);
            if (vecs[v].reload) begin
                if (!k_ready) begin
                    k_clear = 1;
                    tick();
                    k_clear = 0;
                    check("kclear_to_kload", k_ready, 1);
                end
                send_kernel();
            end
            exp_q.push_back(27'(vecs[v].exp_data));
            send_pixels(0, NTAP, 0);
            run_engine(vecs[v].delay);
            drain_out(vecs[v].hold);
        end

        // Random windows with spurious conv_done in FILL and OUT
        for (int r = 0; r < 10; r++) begin
            bit rl;
            rl = 1'($urandom_range(1));
            if (rl) for (int i = 0; i < NTAP; i++) w_arr[i] = int'($urandom_range(511)) - 256;
            for (int i = 0; i < NTAP; i++) p_arr[i] = int'($urandom_range(511)) - 256;
            do_window(rl, int'($urandom_range(1, 40)), int'($urandom_range(0, 4)), 1);
        end

        // Engine never answers: timeout after TMO+1 RUN cycles
        send_pixels(0, NTAP, 0);
        n = 0;
        while (conv_start && n < 400) begin tick(); n++; end
        check("tmo_cycles", n, TMO + 1);
        check("tmo_err_set", err_tmo, 1);
        check("tmo_no_valid", out_valid, 0);
        exp_err = 1;
        tick();
        check("tmo_back_to_fill", px_ready, 1);
        check("tmo_no_valid2", out_valid, 0);
        check("tmo_win_unchanged", win_count, exp_wins);

        // k_clear ignored once pixels have been taken
        for (int i = 0; i < NTAP; i++) p_arr[i] = int'($urandom_range(511)) - 256;
        send_pixels(0, 5, 0);
        k_clear = 1;
        tick();
        k_clear = 0;
        check("kclear_ignored_k_ready", k_ready, 0);
        check("kclear_ignored_px_ready", px_ready, 1);
        exp_q.push_back(model_dot());
        send_pixels(5, NTAP, 0);
        run_engine(7);
        drain_out(1);

        // Reset in the middle of RUN
        send_pixels(0, NTAP, 0);
        tick(); tick();
        check("pre_reset_running", conv_start, 1);
        #2;
        reset = 0;
        #1;
        check("rst_mid_conv_start", conv_start, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_k_ready", k_ready, 0);
        check("rst_mid_px_ready", px_ready, 0);
        check("rst_mid_win_count", win_count, 0);
        check("rst_mid_err_tmo", err_tmo, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_kernel_zero", kernel_bus == '0, 1);
        check("rst_mid_x_zero", x_bus == '0, 1);
        tick(); tick();
        check("rst_hold_k_ready", k_ready, 0);
        reset = 1;
        tick();
        check("reload_required", k_ready, 1);
        exp_wins = 0;
        exp_err  = 0;
        for (int i = 0; i < NTAP; i++) begin
            w_arr[i] = int'($urandom_range(511)) - 256;
            p_arr[i] = int'($urandom_range(511)) - 256;
        end
        do_window(1, 4, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
